// File: rtl/prescaler_multi.sv
// prescaler_multi: NUM_CH runtime-programmable sysclk dividers, each giving a 50% clock and a rise tick.
// Defining PRESCALER_MULTI_SYNC_EN adds i_sync, which phase-aligns all enabled channels.
module prescaler_multi #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_DIV = 600000,
  parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sysclk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_div_wr,
  input  logic [CH_W-1:0]   i_div_sel,
  input  logic [CNT_W-1:0]  i_div_val,
`ifdef PRESCALER_MULTI_SYNC_EN
  input  logic              i_sync,
`endif
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt, act, pend, lim;
    logic pend_vld, clk_q, tick_q, wr, clr, term;
    assign wr = i_div_wr && int'(i_div_sel) == c;
    // a divide of 0 behaves as 1
    assign lim = (act == '0 ? CNT_W'(1) : act) - CNT_W'(1);
    assign term = cnt >= lim;
`ifdef PRESCALER_MULTI_SYNC_EN
    assign clr = !i_en[c] || i_sync;
`else
    assign clr = !i_en[c];
`endif
    // pending divides only reach the active register at a half-period boundary or while cleared
    always_ff @(posedge sysclk or negedge i_rst_n)
      if (!i_rst_n) begin
        cnt <= '0;
        clk_q <= 1'b0;
        tick_q <= 1'b0;
        act <= CNT_W'(DEF_DIV);
        pend <= CNT_W'(DEF_DIV);
        pend_vld <= 1'b0;
      end else if (clr || term) begin
        cnt <= '0;
        clk_q <= clr ? 1'b0 : ~clk_q;
        tick_q <= !clr && !clk_q;
        act <= wr ? i_div_val : pend_vld ? pend : act;
        pend_vld <= 1'b0;
      end else begin
        cnt <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
        if (wr) begin
          pend <= i_div_val;
          pend_vld <= 1'b1;
        end
      end
    assign o_clk[c] = clk_q;
    assign o_tick[c] = tick_q;
  end
endmodule

// File: tb/tb_prescaler_multi.sv
// tb_prescaler_multi: directed and random checks of prescaler_multi against a countdown reference model.
module tb_prescaler_multi;
  localparam int NCH = 3;
  localparam int DEF = 4;
  logic sysclk = 1'b0;
  logic rst_n;
  logic [NCH-1:0] en;
  logic wr;
  logic [1:0] sel;
  logic [15:0] val;
  logic sync;
  logic [NCH-1:0] o_clk, o_tick;
  int errors = 0;
  int checks = 0;
  int m_act [NCH];
  int m_pend [NCH];
  bit m_pv [NCH];
  int m_rem [NCH];
  bit m_lvl [NCH];
  bit m_tick [NCH];

  prescaler_multi #(.NUM_CH(NCH), .CNT_W(16), .DEF_DIV(DEF)) dut (
    .sysclk(sysclk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_div_wr(wr),
    .i_div_sel(sel),
    .i_div_val(val),
`ifdef PRESCALER_MULTI_SYNC_EN
    .i_sync(sync),
`endif
    .o_clk(o_clk),
    .o_tick(o_tick)
  );

  always #5 sysclk = ~sysclk;

  function automatic int eff(int d);
    return d == 0 ? 1 : d;
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      m_act[n] = DEF;
      m_pend[n] = DEF;
      m_pv[n] = 0;
      m_rem[n] = eff(DEF);
      m_lvl[n] = 0;
      m_tick[n] = 0;
    end
  endtask

  // each channel counts down the cycles left in its current half-period
  task automatic model_step();
    for (int n = 0; n < NCH; n++) begin
      bit hit;
      hit = wr && int'(sel) == n;
      if (!en[n] || sync) begin
        m_lvl[n] = 0;
        m_tick[n] = 0;
        m_act[n] = hit ? int'(val) : m_pv[n] ? m_pend[n] : m_act[n];
        m_pv[n] = 0;
        m_rem[n] = eff(m_act[n]);
      end else begin
        m_rem[n]--;
        if (m_rem[n] == 0) begin
          m_tick[n] = !m_lvl[n];
          m_lvl[n] = !m_lvl[n];
          m_act[n] = hit ? int'(val) : m_pv[n] ? m_pend[n] : m_act[n];
          m_pv[n] = 0;
          m_rem[n] = eff(m_act[n]);
        end else begin
          m_tick[n] = 0;
          if (hit) begin
            m_pend[n] = int'(val);
            m_pv[n] = 1;
          end
        end
      end
    end
  endtask

  task automatic step();
    int ec, et;
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    ec = 0;
    et = 0;
    for (int n = 0; n < NCH; n++) begin
      ec |= int'(m_lvl[n]) << n;
      et |= int'(m_tick[n]) << n;
    end
    chk("o_clk", int'(o_clk), ec);
    chk("o_tick", int'(o_tick), et);
  endtask

  task automatic write(int ch, int v);
    wr = 1'b1;
    sel = 2'(ch);
    val = 16'(v);
    step();
    wr = 1'b0;
  endtask

  task automatic wait_level(int ch, bit lvl, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (o_clk[ch] !== lvl && n < 60);
  endtask

  initial begin
    int n, a, b, t0, t1;
    rst_n = 1'b0;
    en = '1;
    wr = 1'b0;
    sel = '0;
    val = '0;
    sync = 1'b0;
    model_reset();
    #1;
    chk("reset_clk", int'(o_clk), 0);
    chk("reset_tick", int'(o_tick), 0);
    @(negedge sysclk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      n += int'(o_tick[0]);
    end
    chk("def_tick_count", n, 4);

    wait_level(1, 0, n);
    wait_level(1, 1, n);
    step();
    write(1, 2);
    wait_level(1, 0, n);
    chk("old_half_rest", n, 2);
    wait_level(1, 1, a);
    chk("new_low_run", a, 2);
    wait_level(1, 0, b);
    chk("new_high_run", b, 2);

    en[2] = 1'b0;
    step();
    write(2, 0);
    en[2] = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n += int'(o_tick[2]);
    end
    chk("clamp_tick_count", n, 4);

    wait_level(0, 0, n);
    wait_level(0, 1, n);
    en[0] = 1'b0;
    step();
    chk("disable_clk0", int'(o_clk[0]), 0);
    step();
    chk("disabled_hold", int'(o_clk[0]), 0);
    en[0] = 1'b1;
    wait_level(0, 1, n);
    chk("reenable_first_rise", n, 4);

    write(0, 7);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_clk", int'(o_clk), 0);
    chk("midrst_tick", int'(o_tick), 0);
    model_reset();
    @(posedge sysclk);
    @(negedge sysclk);
    rst_n = 1'b1;
    wait_level(0, 1, n);
    chk("post_rst_first_rise", n, 4);
    wait_level(0, 0, a);
    wait_level(0, 1, b);
    chk("post_rst_period", a + b, 8);

    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) en[c] = $urandom_range(0, 7) != 0;
      wr = $urandom_range(0, 3) == 0;
      sel = 2'($urandom_range(0, 3));
      val = 16'($urandom_range(0, 6));
      step();
    end
    wr = 1'b0;
    en = '1;

`ifdef PRESCALER_MULTI_SYNC_EN
    en[1:0] = 2'b00;
    write(0, 3);
    write(1, 5);
    en[1:0] = 2'b11;
    for (int i = 0; i < 11; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_clk", int'(o_clk[1:0]), 0);
    t0 = 0;
    t1 = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (o_tick[0] && t0 == 0) t0 = i;
      if (o_tick[1] && t1 == 0) t1 = i;
    end
    chk("sync_tick0", t0, 3);
    chk("sync_tick1", t1, 5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
